// File: rtl/prv_pkg.sv
// Shared PRV32 definitions: IU state codes, BIU FSM states and the reset instruction.
package prv_pkg;

  localparam logic [2:0] ST_FETCH = 3'b000;
  localparam logic [2:0] ST_EXEC  = 3'b001;
  localparam logic [2:0] ST_MEM   = 3'b010;
  localparam logic [2:0] ST_WB    = 3'b011;
  localparam logic [2:0] ST_TRAP  = 3'b100;

  typedef enum logic [1:0] {
    BIU_IDLE,
    BIU_FETCH,
    BIU_MEM,
    BIU_DONE
  } biu_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/prv_biu_align.sv
// Byte-lane steering: store byte enables/data replication and load lane select/extension.
module prv_biu_align (
  input  logic [1:0]  st_off,
  input  logic        st_b,
  input  logic        st_h,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_off,
  input  logic        ld_b,
  input  logic        ld_h,
  input  logic        ld_sext,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    if (st_b) begin
      be    = 4'b0001 << st_off;
      wdata = {4{st_data[7:0]}};
    end else if (st_h) begin
      be    = st_off[1] ? 4'b1100 : 4'b0011;
      wdata = {2{st_data[15:0]}};
    end
  end

  always_comb begin
    shifted = bus_rdata >> {ld_off, 3'b000};
    ld_data = bus_rdata;
    if (ld_b)
      ld_data = {{24{ld_sext & shifted[7]}}, shifted[7:0]};
    else if (ld_h)
      ld_data = {{16{ld_sext & shifted[15]}}, shifted[15:0]};
  end

endmodule

// File: rtl/prv_biu.sv
// PRV32 bus interface unit: one fetch or load/store per IU request on a valid/ack bus,
// with timeout, alignment checks and one-cycle completion/fault pulses.
module prv_biu #(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [31:0] NOP     = prv_pkg::NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  statu,
  input  logic [31:0] pc,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        w8,
  input  logic        w16,
  input  logic        w32,
  input  logic        r8,
  input  logic        r16,
  input  logic        r32,
  input  logic        lb,
  input  logic        lh,
  output logic        rdy_biu,
  output logic [31:0] ins,
  output logic [31:0] rdata,
  output logic        ins_addr_mis,
  output logic        ins_acc_fault,
  output logic        addr_mis,
  output logic        load_acc_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);
  import prv_pkg::*;

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  biu_state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic          is_store, is_load, start_fetch, start_mem, busy, timed_out, fault;
  logic          sz_b, sz_h;
  logic [1:0]    ld_off;
  logic          ld_b, ld_h, ld_sext;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata, ld_data;

  assign ins_addr_mis = (statu == ST_FETCH) && (pc[1:0] != 2'b00);
  assign addr_mis     = (statu == ST_MEM) &&
                        (((w16 | r16) & mem_addr[0]) | ((w32 | r32) & (mem_addr[1:0] != 2'b00)));

  assign is_store    = w8 | w16 | w32;
  assign is_load     = r8 | r16 | r32 | lb | lh;
  assign start_fetch = (state == BIU_IDLE) && (statu == ST_FETCH) && (pc[1:0] == 2'b00);
  assign start_mem   = (state == BIU_IDLE) && (statu == ST_MEM) && !addr_mis && (is_store | is_load);
  assign busy        = (state == BIU_FETCH) || (state == BIU_MEM);
  // The edge that ends the TIMEOUT-th request cycle is where the counter still reads TIMEOUT-1.
  assign timed_out   = (cnt == CW'(TIMEOUT - 1));
  assign fault       = bus_err | timed_out;

  assign sz_b = is_store ? w8  : (r8 | lb);
  assign sz_h = is_store ? w16 : (r16 | lh);

  prv_biu_align u_align (
    .st_off    (mem_addr[1:0]),
    .st_b      (sz_b),
    .st_h      (sz_h),
    .st_data   (mem_wdata),
    .be        (st_be),
    .wdata     (st_wdata),
    .ld_off    (ld_off),
    .ld_b      (ld_b),
    .ld_h      (ld_h),
    .ld_sext   (ld_sext),
    .bus_rdata (bus_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= BIU_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BIU_IDLE: begin
        if (start_fetch)    state_nx = BIU_FETCH;
        else if (start_mem) state_nx = BIU_MEM;
      end
      BIU_FETCH, BIU_MEM: begin
        if (bus_ack | fault) state_nx = BIU_DONE;
      end
      default: state_nx = BIU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_be         <= '0;
      bus_wdata      <= '0;
      rdy_biu        <= 1'b0;
      ins_acc_fault  <= 1'b0;
      load_acc_fault <= 1'b0;
      ins            <= NOP;
      rdata          <= '0;
      cnt            <= '0;
      ld_off         <= '0;
      ld_b           <= 1'b0;
      ld_h           <= 1'b0;
      ld_sext        <= 1'b0;
    end else begin
      rdy_biu        <= 1'b0;
      ins_acc_fault  <= 1'b0;
      load_acc_fault <= 1'b0;
      if (start_fetch) begin
        bus_req  <= 1'b1;
        bus_we   <= 1'b0;
        bus_addr <= {pc[31:2], 2'b00};
        bus_be   <= '1;
        cnt      <= '0;
      end else if (start_mem) begin
        bus_req   <= 1'b1;
        bus_we    <= is_store;
        bus_addr  <= {mem_addr[31:2], 2'b00};
        bus_be    <= st_be;
        bus_wdata <= st_wdata;
        cnt       <= '0;
        ld_off    <= mem_addr[1:0];
        ld_b      <= r8 | lb;
        ld_h      <= r16 | lh;
        ld_sext   <= lb | lh;
      end else if (busy) begin
        if (fault) begin
          bus_req <= 1'b0;
          if (state == BIU_FETCH) ins_acc_fault  <= 1'b1;
          else                    load_acc_fault <= 1'b1;
        end else if (bus_ack) begin
          bus_req <= 1'b0;
          rdy_biu <= 1'b1;
          if (state == BIU_FETCH) ins   <= bus_rdata;
          else if (!bus_we)       rdata <= ld_data;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prv_biu.sv
// Directed scoreboard bench for prv_biu: fetch, loads, stores, misalignment, faults, reset.
module tb_prv_biu;
  import prv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  statu;
  logic [31:0] pc, mem_addr, mem_wdata;
  logic        w8, w16, w32, r8, r16, r32, lb, lh;
  logic        rdy_biu;
  logic [31:0] ins, rdata;
  logic        ins_addr_mis, ins_acc_fault, addr_mis, load_acc_fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  prv_biu #(.TIMEOUT(15), .NOP(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .statu(statu), .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .w8(w8), .w16(w16), .w32(w32), .r8(r8), .r16(r16), .r32(r32), .lb(lb), .lh(lh),
    .rdy_biu(rdy_biu), .ins(ins), .rdata(rdata), .ins_addr_mis(ins_addr_mis),
    .ins_acc_fault(ins_acc_fault), .addr_mis(addr_mis), .load_acc_fault(load_acc_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_strobes();
    {w8, w16, w32, r8, r16, r32, lb, lh} = '0;
  endtask

  // Responds to one access started in cycle 0; acks/errs after `waits` request cycles.
  task automatic run_bus(input string tag, input bit is_fetch, input int waits,
                         input logic [31:0] d, input logic give_ack, input logic give_err,
                         output int req_cyc, output int done_cyc,
                         output logic [31:0] a_addr, output logic [31:0] a_wdata,
                         output logic [3:0] a_be, output logic a_we,
                         output logic d_rdy, output logic d_iaf, output logic d_laf,
                         output logic after_any, output logic stable);
    logic [31:0] e;
    req_cyc = 0; done_cyc = -1; stable = 1'b1;
    a_addr = '0; a_wdata = '0; a_be = '0; a_we = 1'b0;
    d_rdy = 1'b0; d_iaf = 1'b0; d_laf = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      bus_ack = 1'b0; bus_err = 1'b0;
      if (rdy_biu || ins_acc_fault || load_acc_fault) begin
        done_cyc = c;
        d_rdy = rdy_biu; d_iaf = ins_acc_fault; d_laf = load_acc_fault;
        statu = ST_EXEC;
        clr_strobes();
        break;
      end
      if (bus_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          a_addr = bus_addr; a_wdata = bus_wdata; a_be = bus_be; a_we = bus_we;
        end else if (bus_addr !== a_addr || bus_wdata !== a_wdata || bus_be !== a_be || bus_we !== a_we) begin
          stable = 1'b0;
        end
        if (req_cyc > waits) begin
          bus_ack = give_ack; bus_err = give_err; bus_rdata = d;
        end
      end
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk({tag, "_data"}, is_fetch ? ins : rdata, e);
    tick();
    after_any = rdy_biu | ins_acc_fault | load_acc_fault;
  endtask

  int req_cyc, done_cyc, nreq;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        a_we, d_rdy, d_iaf, d_laf, after_any, stable;

  initial begin
    rst = 1'b1; statu = ST_EXEC; pc = '0; mem_addr = '0; mem_wdata = '0;
    clr_strobes(); bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_rdy", {31'b0, rdy_biu}, 32'd0);
    chk("rst_ins", ins, 32'h0000_0013);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_be", {28'b0, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    tick();

    // Fetch with two wait states
    statu = ST_FETCH; pc = 32'h100; exp_q.push_back(32'h0050_0093);
    run_bus("f_wait", 1'b1, 2, 32'h0050_0093, 1'b1, 1'b0, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    chk("f_wait_addr", a_addr, 32'h100);
    chk("f_wait_we", {31'b0, a_we}, 32'd0);
    chk("f_wait_cycle", done_cyc, 32'd4);
    chk("f_wait_rdy", {29'b0, d_rdy, d_iaf, d_laf}, 32'b100);
    chk("f_wait_pulse", {31'b0, after_any}, 32'd0);
    chk("f_wait_stable", {31'b0, stable}, 32'd1);

    // Zero-wait fetch
    statu = ST_FETCH; pc = 32'h104; exp_q.push_back(32'h0000_0033);
    run_bus("f_zero", 1'b1, 0, 32'h0000_0033, 1'b1, 1'b0, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    chk("f_zero_cycle", done_cyc, 32'd2);
    chk("f_zero_addr", a_addr, 32'h104);

    // Misaligned fetch: flag now, no bus request
    statu = ST_FETCH; pc = 32'h102; #1;
    chk("f_mis_flag", {31'b0, ins_addr_mis}, 32'd1);
    nreq = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (bus_req) nreq++; end
    chk("f_mis_noreq", nreq, 32'd0);
    chk("f_mis_ins", ins, 32'h0000_0033);
    statu = ST_EXEC; tick();

    // lb / lbu / lh / lw
    statu = ST_MEM; mem_addr = 32'h203; r8 = 1'b1; lb = 1'b1; exp_q.push_back(32'hFFFF_FF80);
    run_bus("lb", 1'b0, 1, 32'h80FF_0000, 1'b1, 1'b0, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    chk("lb_addr", a_addr, 32'h200);
    chk("lb_we", {31'b0, a_we}, 32'd0);
    statu = ST_MEM; mem_addr = 32'h203; r8 = 1'b1; exp_q.push_back(32'h0000_0080);
    run_bus("lbu", 1'b0, 0, 32'h80FF_0000, 1'b1, 1'b0, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    statu = ST_MEM; mem_addr = 32'h202; r16 = 1'b1; lh = 1'b1; exp_q.push_back(32'hFFFF_80FF);
    run_bus("lh", 1'b0, 0, 32'h80FF_0000, 1'b1, 1'b0, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    statu = ST_MEM; mem_addr = 32'h200; r32 = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
    run_bus("lw", 1'b0, 3, 32'hDEAD_BEEF, 1'b1, 1'b0, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    chk("lw_stable", {31'b0, stable}, 32'd1);

    // Stores leave rdata untouched
    statu = ST_MEM; mem_addr = 32'h302; mem_wdata = 32'h1234_ABCD; w16 = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
    run_bus("sh", 1'b0, 1, 32'h5555_5555, 1'b1, 1'b0, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    chk("sh_be", {28'b0, a_be}, 32'b1100);
    chk("sh_wdata", a_wdata, 32'hABCD_ABCD);
    chk("sh_we", {31'b0, a_we}, 32'd1);
    chk("sh_addr", a_addr, 32'h300);
    statu = ST_MEM; mem_addr = 32'h301; mem_wdata = 32'h0000_00CD; w8 = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
    run_bus("sb", 1'b0, 0, 32'h0, 1'b1, 1'b0, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    chk("sb_be", {28'b0, a_be}, 32'b0010);
    chk("sb_wdata", a_wdata, 32'hCDCD_CDCD);

    // Misaligned store word
    statu = ST_MEM; mem_addr = 32'h301; w32 = 1'b1; #1;
    chk("sw_mis_flag", {31'b0, addr_mis}, 32'd1);
    nreq = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (bus_req) nreq++; end
    chk("sw_mis_noreq", nreq, 32'd0);
    statu = ST_EXEC; clr_strobes(); tick();

    // Fetch timeout
    statu = ST_FETCH; pc = 32'h180; exp_q.push_back(32'h0000_0033);
    run_bus("f_to", 1'b1, 0, 32'h0, 1'b0, 1'b0, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    chk("f_to_reqcyc", req_cyc, 32'd15);
    chk("f_to_cycle", done_cyc, 32'd16);
    chk("f_to_flags", {29'b0, d_rdy, d_iaf, d_laf}, 32'b010);
    chk("f_to_pulse", {31'b0, after_any}, 32'd0);

    // Load with ack and err together: err wins
    statu = ST_MEM; mem_addr = 32'h204; r32 = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
    run_bus("l_err", 1'b0, 1, 32'h1111_1111, 1'b1, 1'b1, req_cyc, done_cyc, a_addr, a_wdata, a_be, a_we, d_rdy, d_iaf, d_laf, after_any, stable);
    chk("l_err_flags", {29'b0, d_rdy, d_iaf, d_laf}, 32'b001);
    chk("l_err_cycle", done_cyc, 32'd3);

    // Reset in the middle of a waited load
    statu = ST_MEM; mem_addr = 32'h400; r32 = 1'b1;
    tick(); tick();
    chk("rst_mid_req_before", {31'b0, bus_req}, 32'd1);
    rst = 1'b1; tick();
    chk("rst_mid_req", {31'b0, bus_req}, 32'd0);
    rst = 1'b0; statu = ST_EXEC; clr_strobes();
    bus_ack = 1'b1; bus_rdata = 32'h2222_2222; tick();
    bus_ack = 1'b0;
    chk("rst_late_rdy", {31'b0, rdy_biu}, 32'd0);
    chk("rst_late_ins", ins, 32'h0000_0013);
    chk("rst_late_rdata", rdata, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
